// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin arbiter sharing one Avalon-MM memory slave among cache m0 masters
// Ports: clk, reset (async, active high);
//   m_address/m_read/m_write/m_writedata in, packed per master (slice i is master i);
//   m_readdata (broadcast) and m_waitrequest (per master) out;
//   s_* drive the shared memory slave; grant is the one-hot owner; busy is high when not idle.
module cache_mem_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_W      = 28,
   parameter int DATA_W      = 32,
   parameter int HOLD_CYCLES = 2,
   parameter int MAX_BURST   = 256
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
   input  logic [NUM_MASTERS-1:0]        m_read,
   input  logic [NUM_MASTERS-1:0]        m_write,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
   output logic [DATA_W-1:0]             m_readdata,
   output logic [NUM_MASTERS-1:0]        m_waitrequest,
   output logic [ADDR_W-1:0]             s_address,
   output logic                          s_read,
   output logic                          s_write,
   output logic [DATA_W-1:0]             s_writedata,
   input  logic [DATA_W-1:0]             s_readdata,
   input  logic                          s_waitrequest,
   output logic [NUM_MASTERS-1:0]        grant,
   output logic                          busy
);
   localparam int OW = $clog2(NUM_MASTERS);
   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
   state_t state, state_n;
   logic [OW-1:0] owner, owner_n, last, last_n, pick, sel;
   logic [8:0] burst_cnt, burst_n;
   logic [3:0] hold_cnt, hold_n;
   logic [NUM_MASTERS-1:0] req, own_oh, cand;
   logic found, own_req, others;
   assign req     = m_read | m_write;
   assign own_oh  = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << owner;
   assign own_req = req[owner];
   assign others  = |(req & ~own_oh);
   // a saturated owner in HOLD must hand over, so it is masked out of the search
   assign cand    = (state == HOLD) ? req & ~own_oh : req;
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         if (!found && cand[OW'((int'(last) + k) % NUM_MASTERS)]) begin
            pick  = OW'((int'(last) + k) % NUM_MASTERS);
            found = 1'b1;
         end
      end
   end
   always_comb begin
      state_n = state;
      owner_n = owner;
      last_n  = last;
      burst_n = burst_cnt;
      hold_n  = hold_cnt;
      case (state)
         IDLE: if (|req) begin
            owner_n = pick;
            last_n  = pick;
            burst_n = '0;
            state_n = BUSY;
         end
         BUSY: if (!own_req) begin
            burst_n = '0;
            state_n = IDLE;
         end else if (!s_waitrequest) begin
            burst_n = (burst_cnt == 9'(MAX_BURST)) ? burst_cnt : burst_cnt + 9'd1;
            hold_n  = 4'(HOLD_CYCLES);
            state_n = HOLD;
         end
         HOLD: if (own_req && (burst_cnt < 9'(MAX_BURST) || !others)) begin
            state_n = BUSY;
         end else if (own_req) begin
            owner_n = pick;
            last_n  = pick;
            burst_n = '0;
            state_n = BUSY;
         end else if (hold_cnt == '0) begin
            burst_n = '0;
            state_n = IDLE;
         end else begin
            hold_n = hold_cnt - 4'd1;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= '0;
         last      <= OW'(NUM_MASTERS - 1);
         burst_cnt <= '0;
         hold_cnt  <= '0;
      end else begin
         state     <= state_n;
         owner     <= owner_n;
         last      <= last_n;
         burst_cnt <= burst_n;
         hold_cnt  <= hold_n;
      end
   end
   // a read+write collision is treated as a read
   assign sel           = (state == IDLE) ? '0 : owner;
   assign s_address     = m_address[int'(sel)*ADDR_W +: ADDR_W];
   assign s_writedata   = m_writedata[int'(sel)*DATA_W +: DATA_W];
   assign s_read        = (state == BUSY) & m_read[sel];
   assign s_write       = (state == BUSY) & m_write[sel] & ~m_read[sel];
   assign m_readdata    = s_readdata;
   assign grant         = (state == IDLE) ? '0 : own_oh;
   assign busy          = state != IDLE;
   assign m_waitrequest = ~(grant & {NUM_MASTERS{state == BUSY && !s_waitrequest}});
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed checks of cache_mem_arbiter (dut_a default, dut_b MAX_BURST=4)
module tb_cache_mem_arbiter;
   localparam int N  = 4;
   localparam int AW = 28;
   localparam int DW = 32;
   localparam logic [AW-1:0] A0 = 28'h0000010;
   localparam logic [AW-1:0] A1 = 28'h0100020;
   localparam logic [AW-1:0] A2 = 28'h0200040;
   localparam logic [AW-1:0] A3 = 28'h0300080;
   localparam logic [DW-1:0] D5 = 32'hCAFE_F00D;
   logic clk = 1'b0;
   logic reset;
   logic [N*AW-1:0] m_address;
   logic [N-1:0] m_read, m_write;
   logic [N*DW-1:0] m_writedata;
   logic [DW-1:0] s_readdata;
   logic s_waitrequest;
   logic [DW-1:0] rd_a, rd_b, swd_a, swd_b;
   logic [N-1:0] wreq_a, wreq_b, grant_a, grant_b;
   logic [AW-1:0] sa_a, sa_b;
   logic sr_a, sr_b, sw_a, sw_b, busy_a, busy_b;
   int n_chk = 0;
   int n_pass = 0;
   always #5 clk = ~clk;
   cache_mem_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .HOLD_CYCLES(2), .MAX_BURST(256)) dut_a (
      .clk(clk), .reset(reset), .m_address(m_address), .m_read(m_read), .m_write(m_write),
      .m_writedata(m_writedata), .m_readdata(rd_a), .m_waitrequest(wreq_a), .s_address(sa_a),
      .s_read(sr_a), .s_write(sw_a), .s_writedata(swd_a), .s_readdata(s_readdata),
      .s_waitrequest(s_waitrequest), .grant(grant_a), .busy(busy_a));
   cache_mem_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .HOLD_CYCLES(2), .MAX_BURST(4)) dut_b (
      .clk(clk), .reset(reset), .m_address(m_address), .m_read(m_read), .m_write(m_write),
      .m_writedata(m_writedata), .m_readdata(rd_b), .m_waitrequest(wreq_b), .s_address(sa_b),
      .s_read(sr_b), .s_write(sw_b), .s_writedata(swd_b), .s_readdata(s_readdata),
      .s_waitrequest(s_waitrequest), .grant(grant_b), .busy(busy_b));
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   // one transfer: called just after a rising edge, returns just after the completing edge
   // with the request dropped; waits counts cycles seen with waitrequest high
   task automatic xfer(input bit b, input int i, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int waits);
      waits = 0;
      m_address[i*AW +: AW]   = a;
      m_writedata[i*DW +: DW] = d;
      if (wr) m_write[i] = 1'b1;
      else m_read[i] = 1'b1;
      #1;
      while ((b ? wreq_b[i] : wreq_a[i]) && waits < 40) begin
         @(posedge clk); #2;
         waits++;
      end
      @(posedge clk); #1;
      m_read[i]  = 1'b0;
      m_write[i] = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
   initial begin
      int w;
      reset = 1'b1; m_address = '0; m_read = '0; m_write = '0; m_writedata = '0;
      s_readdata = '0; s_waitrequest = 1'b0;
      @(posedge clk); #1;
      check("rst_grant", grant_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_wreq", wreq_a, 4'hF);
      check("rst_sread", sr_a, 0);
      check("rst_swrite", sw_a, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #2;
         check("idle_grant", grant_a, 0);
         check("idle_busy", busy_a, 0);
         check("idle_wreq", wreq_a, 4'hF);
         check("idle_sread", sr_a, 0);
      end
      s_readdata = 32'hDEAD_BEEF;
      #1 check("readdata_bcast", rd_a, 32'hDEAD_BEEF);
      // masters 0 and 2 together: 0 first, 2 after 0's hold expires
      @(posedge clk); #1;
      m_address[2*AW +: AW] = A2;
      m_read[2] = 1'b1;
      xfer(0, 0, 0, A0, '0, w);
      check("t2_m0_waits", w, 1);
      #1;
      check("t2_hold_grant", grant_a, 4'b0001);
      check("t2_hold_wreq", wreq_a, 4'hF);
      check("t2_hold_sread", sr_a, 0);
      @(posedge clk); #2 check("t2_hold1_grant", grant_a, 4'b0001);
      @(posedge clk); #2 check("t2_hold0_grant", grant_a, 4'b0001);
      @(posedge clk); #2;
      check("t2_idle_grant", grant_a, 0);
      check("t2_idle_busy", busy_a, 0);
      @(posedge clk); #2;
      check("t2_m2_grant", grant_a, 4'b0100);
      check("t2_m2_addr", sa_a, A2);
      check("t2_m2_sread", sr_a, 1);
      check("t2_m2_wreq", wreq_a, 4'b1011);
      @(posedge clk); #1;
      m_read[2] = 1'b0;
      repeat (3) @(posedge clk);
      #2 check("t2_end_busy", busy_a, 0);
      // 8-word line fill by master 1; master 3 asks mid-burst
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++) begin
         xfer(0, 1, 0, AW'(A1 + k), '0, w);
         check("t3_word_waits", w, 1);
         #1;
         check("t3_gap_grant", grant_a, 4'b0010);
         check("t3_m3_wreq", wreq_a[3], 1);
         if (k == 1) begin
            m_address[3*AW +: AW] = A3;
            m_read[3] = 1'b1;
         end
         @(posedge clk); #1;
      end
      xfer(0, 3, 0, A3, '0, w);
      check("t3_m3_waits", w, 3);
      #1 check("t3_m3_grant", grant_a, 4'b1000);
      repeat (3) @(posedge clk);
      #2 check("t3_end_busy", busy_a, 0);
      // slave stalls a write from master 2 for 5 cycles
      @(posedge clk); #1;
      s_waitrequest = 1'b1;
      m_address[2*AW +: AW]   = A2;
      m_writedata[2*DW +: DW] = D5;
      m_write[2] = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("t5_swrite", sw_a, 1);
         check("t5_m2_wreq", wreq_a[2], 1);
         check("t5_wdata", swd_a, D5);
         check("t5_grant", grant_a, 4'b0100);
         @(posedge clk); #1;
      end
      s_waitrequest = 1'b0;
      #1;
      check("t5_done_wreq", wreq_a[2], 0);
      check("t5_done_swrite", sw_a, 1);
      @(posedge clk); #1;
      m_write[2] = 1'b0;
      #1;
      check("t5_hold_swrite", sw_a, 0);
      check("t5_hold_busy", busy_a, 1);
      check("t5_hold_wreq", wreq_a, 4'hF);
      repeat (3) @(posedge clk);
      #2 check("t5_end_busy", busy_a, 0);
      // read+write collision on master 1, then reset mid-transfer
      @(posedge clk); #1;
      s_waitrequest = 1'b1;
      m_address[1*AW +: AW] = A1;
      m_read[1]  = 1'b1;
      m_write[1] = 1'b1;
      @(posedge clk); #2;
      check("t6_grant", grant_a, 4'b0010);
      check("t6_sread", sr_a, 1);
      check("t6_swrite_suppressed", sw_a, 0);
      reset = 1'b1;
      #1;
      check("t6_rst_sread", sr_a, 0);
      check("t6_rst_busy", busy_a, 0);
      check("t6_rst_grant", grant_a, 0);
      check("t6_rst_wreq", wreq_a, 4'hF);
      m_read[1] = 1'b0;
      m_write[1] = 1'b0;
      s_waitrequest = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      m_address[0 +: AW] = A0;
      m_address[2*AW +: AW] = A2;
      m_read[0] = 1'b1;
      m_read[2] = 1'b1;
      @(posedge clk); #2;
      check("t6_prio_grant", grant_a, 4'b0001);
      check("t6_prio_addr", sa_a, A0);
      m_read = '0;
      // MAX_BURST=4 on dut_b: master 1 cuts in after 4 words of master 0
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      m_address[1*AW +: AW] = A1;
      m_read[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         xfer(1, 0, 0, AW'(A0 + k), '0, w);
         check("t4_word_waits", w, 1);
         #1 check("t4_gap_grant", grant_b, 4'b0001);
         @(posedge clk); #1;
      end
      m_read[0] = 1'b1;
      #1;
      check("t4_sat_grant", grant_b, 4'b0001);
      check("t4_sat_wreq", wreq_b, 4'hF);
      @(posedge clk); #2;
      check("t4_m1_grant", grant_b, 4'b0010);
      check("t4_m1_wreq", wreq_b, 4'b1101);
      check("t4_m1_addr", sa_b, A1);
      @(posedge clk); #1;
      m_read[1] = 1'b0;
      xfer(1, 0, 0, AW'(A0 + 4), '0, w);
      check("t4_word5_waits", w, 4);
      for (int k = 5; k < 10; k++) begin
         @(posedge clk); #1;
         xfer(1, 0, 0, AW'(A0 + k), '0, w);
         check("t4_tail_waits", w, 1);
      end
      #1 check("t4_tail_grant", grant_b, 4'b0001);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
